uart_slave_port: RTL

Parametrised byte-level successor of the UART master/slave bridge. It sits between the uart_rx/uart_tx serialisers and two clients: the UartProtocol engine (tagged bytes, bit7=1) and a CPU bus slave (data bytes, bit7=0). Compared with the previous generation it adds:
- configurable FIFO depths;
- selectable TX arbitration priority;
- sticky overrun/overflow flags;
- FIFO flush;
- RX level readback;
- maskable interrupts;
- single-commit bus accesses with registered read data.

---
 rtl/uart_slave_pkg.sv | 30 +++
 rtl/uart_byte_fifo.sv | 80 ++++++++
 rtl/uart_slave_port.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_slave_pkg.sv
// uart_slave_pkg
//   Shared constants for the UART slave port: bus register addresses,
//   STATUS register bit positions and IRQ_EN bit positions.
package uart_slave_pkg;

    // Bus register map (i_slave_addr)
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_IRQ_EN = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;

    // STATUS register bit positions
    localparam int ST_RX_EMPTY  = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_TX_EMPTY  = 2;
    localparam int ST_TX_FULL   = 3;
    localparam int ST_OVR       = 4;
    localparam int ST_TXOVF     = 5;
    localparam int ST_PBUF_FULL = 6;

    // IRQ_EN register bit positions
    localparam int IRQ_RX_AVAIL = 0;
    localparam int IRQ_TX_EMPTY = 1;
    localparam int IRQ_ERR      = 2;

    // LEVEL register write bits
    localparam int FLUSH_RX = 0;
    localparam int FLUSH_TX = 1;

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo
//   Byte FIFO of depth 2**AW with synchronous push, pop and flush.
//   Ports:
//     i_clk, i_reset_n   clock, asynchronous active-low reset
//     i_push, i_push_dat push strobe and byte
//     i_pop              pop strobe (ignored when empty)
//     i_flush            empties the FIFO; wins over a same-cycle push/pop
//     o_head             byte at the read pointer (valid when not empty)
//     o_level            number of stored bytes, 0..2**AW
//     o_empty, o_full    occupancy flags
module uart_byte_fifo #(
    parameter int AW = 2
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_push,
    input  logic [7:0]    i_push_dat,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [7:0]    o_head,
    output logic [AW:0]   o_level,
    output logic          o_empty,
    output logic          o_full
);

    localparam int DEPTH = 1 << AW;
    localparam int PW    = (AW > 0) ? AW : 1;
    localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
    localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign o_empty = (count == '0);
    assign o_full  = (count == FULL_LVL);
    assign o_level = count;
    assign o_head  = mem[rd_ptr];

    // A pop on an empty FIFO does nothing; a push on a full FIFO only
    // succeeds when a pop frees a slot in the same cycle.
    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    // Storage array; not reset because the count gates every read of it.
    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) begin
            mem[wr_ptr] <= i_push_dat;
        end
    end

    // Pointers and count; flush takes priority over push and pop.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_slave_port.sv
// uart_slave_port
//   Byte-level bridge between uart_rx/uart_tx and two clients: the protocol
//   engine (tagged bytes, bit7=1) and a CPU bus slave (data bytes, bit7=0).
//   Ports:
//     i_clk, i_reset_n                 clock, asynchronous active-low reset
//     i_rx_dat, i_rx_pulse             received byte and strobe
//     o_tx_dat, o_tx_start, i_tx_ready byte/start to uart_tx, uart_tx idle
//     o_prot_rx_dat, o_prot_rx_pulse   tagged payload to the protocol engine
//     i_prot_tx_dat, i_prot_tx_pulse   protocol byte to send and strobe
//     o_prot_tx_ready                  protocol buffer empty
//     i_slave_addr/_data/_we/_cs       bus access, committed on cs rising
//     o_slave_data, o_slave_ack        registered read data, acknowledge
//     o_int                            registered interrupt request
module uart_slave_port
    import uart_slave_pkg::*;
#(
    parameter int RX_AW      = 2,
    parameter int TX_AW      = 1,
    parameter bit PROT_FIRST = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_rx_dat,
    input  logic       i_rx_pulse,
    output logic [7:0] o_tx_dat,
    output logic       o_tx_start,
    input  logic       i_tx_ready,
    output logic [7:0] o_prot_rx_dat,
    output logic       o_prot_rx_pulse,
    input  logic [7:0] i_prot_tx_dat,
    input  logic       i_prot_tx_pulse,
    output logic       o_prot_tx_ready,
    input  logic [1:0] i_slave_addr,
    input  logic [7:0] i_slave_data,
    output logic [7:0] o_slave_data,
    input  logic       i_slave_we,
    input  logic       i_slave_cs,
    output logic       o_slave_ack,
    output logic       o_int
);

    logic [7:0]     rx_head, tx_head;
    logic [RX_AW:0] rx_level;
    logic [TX_AW:0] tx_level;
    logic           rx_empty, rx_full, tx_empty, tx_full;
    logic           rx_push, rx_pop, rx_flush;
    logic           tx_push, tx_pop, tx_flush;

    logic           cs_q, commit, rd_commit, wr_commit;
    logic           pbuf_full, pbuf_load, pbuf_pop;
    logic [6:0]     pbuf_dat;
    logic           lockout, start_now, pick_prot;
    logic           ovr, txovf, ovr_set, txovf_set, ovr_clr, txovf_clr;
    logic [2:0]     irq_en, irq_src;
    logic [7:0]     status, rd_val;
    logic           unused_bits;

    // The bus acknowledge is simply cs delayed by one cycle, which gives
    // ack from the cycle after commit until the cycle after cs falls.
    assign commit      = i_slave_cs & ~cs_q;
    assign rd_commit   = commit & ~i_slave_we;
    assign wr_commit   = commit & i_slave_we;
    assign o_slave_ack = cs_q;

    assign rx_push  = i_rx_pulse & ~i_rx_dat[7];
    assign rx_pop   = rd_commit & (i_slave_addr == REG_DATA);
    assign rx_flush = wr_commit & (i_slave_addr == REG_LEVEL) & i_slave_data[FLUSH_RX];
    assign tx_push  = wr_commit & (i_slave_addr == REG_DATA);
    assign tx_flush = wr_commit & (i_slave_addr == REG_LEVEL) & i_slave_data[FLUSH_TX];

    assign pbuf_load       = i_prot_tx_pulse & ~pbuf_full;
    assign o_prot_tx_ready = ~pbuf_full;

    // A dropped byte raises its sticky flag; a pop in the same cycle or a
    // flush means nothing was lost. Set beats a same-cycle write-1-clear.
    assign ovr_set   = rx_push & rx_full & ~rx_pop & ~rx_flush;
    assign txovf_set = tx_push & tx_full & ~tx_pop & ~tx_flush;
    assign ovr_clr   = wr_commit & (i_slave_addr == REG_STATUS) & i_slave_data[ST_OVR];
    assign txovf_clr = wr_commit & (i_slave_addr == REG_STATUS) & i_slave_data[ST_TXOVF];

    assign unused_bits = ^{i_prot_tx_dat[7], tx_head[7], tx_level};

    uart_byte_fifo #(.AW(RX_AW)) u_rx_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_push     (rx_push),
        .i_push_dat ({1'b0, i_rx_dat[6:0]}),
        .i_pop      (rx_pop),
        .i_flush    (rx_flush),
        .o_head     (rx_head),
        .o_level    (rx_level),
        .o_empty    (rx_empty),
        .o_full     (rx_full)
    );

    uart_byte_fifo #(.AW(TX_AW)) u_tx_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_push     (tx_push),
        .i_push_dat (i_slave_data),
        .i_pop      (tx_pop),
        .i_flush    (tx_flush),
        .o_head     (tx_head),
        .o_level    (tx_level),
        .o_empty    (tx_empty),
        .o_full     (tx_full)
    );

    // TX arbitration: start whenever uart_tx is idle, we are not in the
    // one-cycle lockout after the previous start, and something is pending.
    // The chosen source is popped on the same edge the start is seen.
    always_comb begin
        start_now  = i_tx_ready & ~lockout & (pbuf_full | ~tx_empty);
        pick_prot  = pbuf_full & (PROT_FIRST | tx_empty);
        pbuf_pop   = start_now & pick_prot;
        tx_pop     = start_now & ~pick_prot;
        o_tx_start = start_now;
        o_tx_dat   = 8'h00;
        if (start_now) begin
            o_tx_dat = pick_prot ? {1'b1, pbuf_dat} : {1'b0, tx_head[6:0]};
        end
    end

    // Register read mux and interrupt sources.
    always_comb begin
        status  = {1'b0, pbuf_full, txovf, ovr, tx_full, tx_empty, rx_full, rx_empty};
        irq_src = {ovr | txovf, tx_empty, ~rx_empty};
        rd_val  = 8'h00;
        case (i_slave_addr)
            REG_STATUS: rd_val = status;
            REG_DATA:   rd_val = rx_empty ? 8'h00 : rx_head;
            REG_IRQ_EN: rd_val = {5'b0, irq_en};
            REG_LEVEL:  rd_val = 8'(rx_level);
            default:    rd_val = 8'h00;
        endcase
    end

    // Bus side: commit edge detection, captured read data, IRQ enable,
    // sticky error flags and the registered interrupt output.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cs_q         <= 1'b0;
            o_slave_data <= 8'h00;
            irq_en       <= 3'b000;
            ovr          <= 1'b0;
            txovf        <= 1'b0;
            o_int        <= 1'b0;
        end else begin
            cs_q  <= i_slave_cs;
            ovr   <= ovr_set | (ovr & ~ovr_clr);
            txovf <= txovf_set | (txovf & ~txovf_clr);
            o_int <= |(irq_en & irq_src);
            if (commit) begin
                o_slave_data <= rd_val;
            end
            if (wr_commit && (i_slave_addr == REG_IRQ_EN)) begin
                irq_en <= i_slave_data[2:0];
            end
        end
    end

    // UART side: protocol RX strobe, protocol TX buffer and start lockout.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_prot_rx_pulse <= 1'b0;
            o_prot_rx_dat   <= 8'h00;
            pbuf_full       <= 1'b0;
            pbuf_dat        <= 7'h00;
            lockout         <= 1'b0;
        end else begin
            o_prot_rx_pulse <= i_rx_pulse & i_rx_dat[7];
            if (i_rx_pulse && i_rx_dat[7]) begin
                o_prot_rx_dat <= {1'b0, i_rx_dat[6:0]};
            end
            if (pbuf_load) begin
                pbuf_full <= 1'b1;
                pbuf_dat  <= i_prot_tx_dat[6:0];
            end else if (pbuf_pop) begin
                pbuf_full <= 1'b0;
            end
            lockout <= start_now;
        end
    end

endmodule
